// File: rtl/adder4_operand_seq.sv
// adder4_operand_seq: gathers two operand beats from a single upstream stream
// and holds them as an A/B pair until the downstream adder takes them.
module adder4_operand_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             busy,
    output logic [7:0]       pair_cnt
);
    typedef enum logic [1:0] {S_A, S_B, S_OUT} state_t;
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_op_valid;
    logic [7:0]       r_pair_cnt;
    logic             w_accept;
    logic             w_xfer;
    assign in_ready = !rst && r_state != S_OUT;
    assign busy     = r_state != S_A;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_valid = r_op_valid;
    assign pair_cnt = r_pair_cnt;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_xfer   = r_state == S_OUT && op_ready && !flush;
    // flush overrides everything and always returns to awaiting operand A
    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = S_A;
        else if (r_state == S_A)
            w_next = w_accept ? S_B : S_A;
        else if (r_state == S_B)
            w_next = w_accept ? S_OUT : S_B;
        else
            w_next = op_ready ? S_A : S_OUT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_A;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_valid <= 1'b0;
            r_pair_cnt <= 8'd0;
        end else begin
            r_state    <= w_next;
            r_op_valid <= w_next == S_OUT;
            if (w_accept && r_state == S_A)
                r_op_a <= in_data;
            if (w_accept && r_state == S_B)
                r_op_b <= in_data;
            if (w_xfer)
                r_pair_cnt <= r_pair_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_adder4_operand_seq.sv
// tb_adder4_operand_seq: directed vector table, async-reset and wrap sequences,
// then random traffic checked against a beat-queue reference model.
module tb_adder4_operand_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic       busy;
    logic [7:0] pair_cnt;

    int n_cmp = 0;
    int n_err = 0;

    adder4_operand_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .op_a(op_a), .op_b(op_b),
        .op_valid(op_valid), .op_ready(op_ready), .busy(busy), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       fl;
        logic       rdy;
        logic       e_rdy;
        logic       e_ov;
        logic       e_busy;
        logic [3:0] e_a;
        logic [3:0] e_b;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[18];

    // reference model: the beats collected for the pair currently being built
    logic [3:0] m_q[$];
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [7:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [3:0] d, input logic fl, input logic rdy,
                                input logic e_rdy, input logic e_ov, input logic e_busy,
                                input logic [3:0] e_a, input logic [3:0] e_b, input logic [7:0] e_cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.fl = fl; v.rdy = rdy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_busy = e_busy;
        v.e_a = e_a; v.e_b = e_b; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_a = 4'h0;
        m_b = 4'h0;
        m_cnt = 8'd0;
    endtask

    task automatic model_edge(input logic iv, input logic [3:0] d, input logic fl, input logic rdy);
        if (fl)
            m_q.delete();
        else if (m_q.size() == 2) begin
            if (rdy) begin
                m_cnt = m_cnt + 8'd1;
                m_q.delete();
            end
        end else if (iv) begin
            m_q.push_back(d);
            if (m_q.size() == 1) m_a = d;
            else m_b = d;
        end
    endtask

    task automatic mstep(input logic iv, input logic [3:0] d, input logic fl, input logic rdy);
        in_valid = iv; in_data = d; flush = fl; op_ready = rdy;
        @(posedge clk);
        model_edge(iv, d, fl, rdy);
        #1;
        chk("in_ready", in_ready, m_q.size() < 2);
        chk("op_valid", op_valid, m_q.size() == 2);
        chk("busy", busy, m_q.size() != 0);
        chk("pair_cnt", pair_cnt, m_cnt);
        if (m_q.size() == 2) begin
            chk("op_a", op_a, m_q[0]);
            chk("op_b", op_b, m_q[1]);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 4'h3, 0, 1, 1, 0, 1, 4'h3, 4'h0, 8'd0);
        tbl[1]  = mk(1, 4'h9, 0, 1, 0, 1, 1, 4'h3, 4'h9, 8'd0);
        tbl[2]  = mk(1, 4'hE, 0, 1, 1, 0, 0, 4'h3, 4'h9, 8'd1);
        tbl[3]  = mk(1, 4'h7, 0, 0, 1, 0, 1, 4'h7, 4'h9, 8'd1);
        tbl[4]  = mk(1, 4'h4, 1, 0, 1, 0, 0, 4'h7, 4'h9, 8'd1);
        tbl[5]  = mk(1, 4'h2, 0, 0, 1, 0, 1, 4'h2, 4'h9, 8'd1);
        tbl[6]  = mk(1, 4'h5, 0, 0, 0, 1, 1, 4'h2, 4'h5, 8'd1);
        tbl[7]  = mk(0, 4'h0, 1, 1, 1, 0, 0, 4'h2, 4'h5, 8'd1);
        tbl[8]  = mk(0, 4'h0, 0, 1, 1, 0, 0, 4'h2, 4'h5, 8'd1);
        tbl[9]  = mk(1, 4'hF, 0, 0, 1, 0, 1, 4'hF, 4'h5, 8'd1);
        tbl[10] = mk(1, 4'h1, 0, 0, 0, 1, 1, 4'hF, 4'h1, 8'd1);
        for (int i = 11; i < 16; i++)
            tbl[i] = mk(1, 4'h6, 0, 0, 0, 1, 1, 4'hF, 4'h1, 8'd1);
        tbl[16] = mk(1, 4'h6, 0, 1, 1, 0, 0, 4'hF, 4'h1, 8'd2);
        tbl[17] = mk(0, 4'h0, 0, 0, 1, 0, 0, 4'hF, 4'h1, 8'd2);

        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_pair_cnt", pair_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 18; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].d; flush = tbl[i].fl; op_ready = tbl[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_op_valid", i), op_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_op_a", i), op_a, tbl[i].e_a);
            chk($sformatf("tbl%0d_op_b", i), op_b, tbl[i].e_b);
            chk($sformatf("tbl%0d_pair_cnt", i), pair_cnt, tbl[i].e_cnt);
        end

        // async reset landing between edges while a pair is presented
        in_valid = 1; in_data = 4'hA; op_ready = 0; flush = 0;
        @(posedge clk); #1;
        in_data = 4'hB;
        @(posedge clk); #1;
        chk("pre_ar_op_valid", op_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_op_valid", op_valid, 0);
        chk("ar_op_a", op_a, 0);
        chk("ar_op_b", op_b, 0);
        chk("ar_pair_cnt", pair_cnt, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_busy", busy, 0);
        @(posedge clk); #1;
        chk("ar_hold_in_ready", in_ready, 0);
        chk("ar_hold_op_a", op_a, 0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("ar_rel_in_ready", in_ready, 1);

        // 256 back-to-back pairs wrap the counter
        for (int i = 0; i < 768; i++) begin
            mstep(1, 4'($urandom), 0, 1);
            if (i == 2) chk("wrap_first_pair", pair_cnt, 1);
            if (i == 383) chk("wrap_half", pair_cnt, 128);
        end
        chk("wrap_cnt_zero", pair_cnt, 0);

        for (int i = 0; i < 2000; i++)
            mstep(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 15) == 0,
                  1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
